oled_fb_arbiter: RTL and testbench
==================================

# oled_fb_arbiter

Shares one single-port synchronous framebuffer RAM between two requesters: the camera pixel writer (valid/ready stream) and the SPI OLED XY scan core (x/y/next_pixel read side). Display reads are deadline-critical and always win; camera writes are buffered in a small FIFO and drained in free cycles. The block sits between the camera capture path, the framebuffer RAM and the OLED scan core's `color` input.

## Interface
- `c_x_size`, 80: screen width in pixels
- `c_y_size`, 60: screen height in pixels
- `c_color_bits`, 16: pixel width (8 or 16)
- `c_addr_bits`, $clog2(c_x_size*c_y_size): RAM address width (13 at defaults)
- `c_fifo_depth`, 4: camera write FIFO entries (power of 2, ≥2)
- `clk`  in  1  single clock for all logic
- `reset`  in  1  synchronous, active-high reset
- `disp_x`  in  $clog2(c_x_size)  scan core pixel X
- `disp_y`  in  $clog2(c_y_size)  scan core pixel Y
- `disp_next`  in  1  one-cycle pulse when disp_x/disp_y change
- `disp_color`  out  c_color_bits  registered pixel for current disp_x/disp_y
- `cam_valid`  in  1  camera pixel valid
- `cam_ready`  out  1  FIFO can accept
- `cam_sof`  in  1  qualifies the beat as first pixel of a frame
- `cam_data`  in  c_color_bits  camera pixel
- `mem_addr`  out  c_addr_bits  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  c_color_bits  RAM write data
- `mem_rdata`  in  c_color_bits  RAM read data, valid one cycle after address
- `wr_frame_done`  out  1  one-cycle pulse when the last pixel of a frame is written

## Operation
- Address = y*c_x_size + x for both sides; computed with constant multiply, width c_addr_bits.
- Read side: `rd_pend` set on `disp_next` (or by reset release, for pixel (0,0)); captures disp_x/disp_y at that edge. A new `disp_next` while a read is pending or in flight supersedes it: latest coordinates are used, only one `disp_color` update results.
- Out-of-range coordinates (x ≥ c_x_size or y ≥ c_y_size): no RAM read, `disp_color` loads 0.
- Arbiter states: IDLE → RD (read issued, mem_we=0) → RD_CAP (capture mem_rdata into disp_color) → IDLE. In IDLE with `rd_pend`=0 and FIFO non-empty: one write per cycle (mem_we=1, pop FIFO), stay IDLE. `rd_pend` always beats writes. RD_CAP may issue a write in the same cycle if FIFO non-empty (RAM port free).
- Write side: accepted beat = cam_valid & cam_ready. `cam_ready` = !fifo_full (no same-cycle pop bypass). Write counter: beat with cam_sof uses address 0 and next becomes 1; otherwise uses counter and increments; wraps from c_x_size*c_y_size−1 to 0. FIFO entry = {addr, data}.
- `wr_frame_done` pulses the cycle the RAM write to address c_x_size*c_y_size−1 is issued.
- `mem_addr`/`mem_wdata` hold last value when idle; `mem_we` is 0 except on write cycles.

## Timing
- Reset values: disp_color=0, mem_we=0, mem_addr=0, mem_wdata=0, cam_ready=0 during reset then 1, wr_frame_done=0, FIFO empty, write counter 0, state IDLE, rd_pend=1 on first cycle after reset.
- Read latency: disp_next sampled at edge N → RD at N+1 (mem_addr=read addr) → mem_rdata at N+2 → disp_color updated at edge N+3. Fixed, independent of FIFO load.
- Write latency: beat accepted at edge N with FIFO empty and no read → mem_we at N+1.
- Write throughput: 1/cycle except RD cycles; scan core requests one read per ≥32 cycles, so sustained camera rate ≤ ~30/32 never stalls with depth 4.
- Reset mid-operation: FIFO flushed, in-flight read discarded, counter to 0; pending camera data lost.
- Simultaneous push and pop: both occur; count unchanged.

## Test plan
- Reset release with RAM[0]=16'hF800 → mem_addr=0, mem_we=0 at cycle 1; disp_color=16'hF800 at cycle 3.
- disp_next with x=79,y=59 → mem_addr=4799 one cycle later, disp_color=RAM[4799] 3 cycles after pulse; x=80 → disp_color=0, no RAM access.
- Camera stream of 4800 pixels (first with cam_sof) at full rate, scan core pulsing every 32 cycles → every RAM[i]=pixel i, no disp_color latency change, one wr_frame_done pulse.
- Hold off pops with back-to-back disp_next reads: FIFO fills after 4 beats → cam_ready=0; reads complete → FIFO drains in order, cam_ready=1.
- cam_sof mid-frame at counter 1234 → that pixel to address 0, next to 1; no wr_frame_done for aborted frame.
- Reset asserted with 3 FIFO entries and read in flight → no mem_we after reset, disp_color=0, then fresh read of (0,0).

Source files
------------

// File: rtl/oled_fb_arbiter.sv
// Shares one single-port framebuffer RAM: display reads (fixed 3-cycle latency, always win) and
// buffered camera writes drained in free cycles; cam_ready drops only when the write FIFO is full.
module oled_fb_arbiter #(
    parameter int c_x_size     = 80,
    parameter int c_y_size     = 60,
    parameter int c_color_bits = 16,
    parameter int c_addr_bits  = $clog2(c_x_size * c_y_size),
    parameter int c_fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(c_x_size)-1:0]   disp_x,
    input  logic [$clog2(c_y_size)-1:0]   disp_y,
    input  logic                          disp_next,
    output logic [c_color_bits-1:0]       disp_color,
    input  logic                          cam_valid,
    output logic                          cam_ready,
    input  logic                          cam_sof,
    input  logic [c_color_bits-1:0]       cam_data,
    output logic [c_addr_bits-1:0]        mem_addr,
    output logic                          mem_we,
    output logic [c_color_bits-1:0]       mem_wdata,
    input  logic [c_color_bits-1:0]       mem_rdata,
    output logic                          wr_frame_done
);

    localparam int PIX = c_x_size * c_y_size;
    localparam int FAW = $clog2(c_fifo_depth);
    localparam int EW  = c_addr_bits + c_color_bits;
    localparam logic [c_addr_bits-1:0] LAST_ADDR = c_addr_bits'(PIX - 1);
    localparam logic [FAW:0]           FULL_CNT  = (FAW + 1)'(c_fifo_depth);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_RD_CAP} state_t;

    state_t                   state_q;
    logic                     rd_pend_q;
    logic                     rd_oob_q;
    logic                     fl_oob_q;
    logic [c_addr_bits-1:0]   rd_addr_q;
    logic [c_addr_bits-1:0]   rd_addr_d;
    logic                     rd_oob_d;
    logic [c_color_bits-1:0]  disp_color_q;
    logic [c_addr_bits-1:0]   mem_addr_q;
    logic                     mem_we_q;
    logic [c_color_bits-1:0]  mem_wdata_q;
    logic                     wr_frame_done_q;

    logic [EW-1:0]            fifo_q [c_fifo_depth];
    logic [FAW-1:0]           wr_ptr_q;
    logic [FAW-1:0]           rd_ptr_q;
    logic [FAW:0]             count_q;
    logic [c_addr_bits-1:0]   wr_cnt_q;
    logic [c_addr_bits-1:0]   wr_cnt_d;
    logic [c_addr_bits-1:0]   push_addr;
    logic [c_addr_bits-1:0]   head_addr;
    logic [c_color_bits-1:0]  head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;

    always_comb begin
        rd_addr_d = c_addr_bits'(disp_y) * c_addr_bits'(c_x_size) + c_addr_bits'(disp_x);
        rd_oob_d  = (int'(disp_x) >= c_x_size) || (int'(disp_y) >= c_y_size);
        push_addr = cam_sof ? '0 : wr_cnt_q;
        wr_cnt_d  = (push_addr == LAST_ADDR) ? '0 : push_addr + c_addr_bits'(1);
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        cam_ready  = !fifo_full && !reset;
        push       = cam_valid && cam_ready;
        // A pending read owns the next RAM cycle, so no write may be scheduled into it.
        pop        = !rd_pend_q && !fifo_empty;
        {head_addr, head_data} = fifo_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {push_addr, cam_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FAW'(1);
                wr_cnt_q <= wr_cnt_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FAW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (FAW + 1)'(1);
                2'b01:   count_q <= count_q - (FAW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rd_pend_q       <= 1'b1;
            rd_addr_q       <= '0;
            rd_oob_q        <= 1'b0;
            fl_oob_q        <= 1'b0;
            disp_color_q    <= '0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            wr_frame_done_q <= 1'b0;
        end else begin
            mem_we_q        <= 1'b0;
            wr_frame_done_q <= 1'b0;
            if (disp_next) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= rd_addr_d;
                rd_oob_q  <= rd_oob_d;
            end
            if (rd_pend_q) begin
                // Re-entering RD from any state restarts the read, so a superseded one never lands.
                state_q  <= ST_RD;
                fl_oob_q <= rd_oob_q;
                if (!rd_oob_q) begin
                    mem_addr_q <= rd_addr_q;
                end
                if (!disp_next) begin
                    rd_pend_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_RD: state_q <= ST_RD_CAP;
                    ST_RD_CAP: begin
                        state_q <= ST_IDLE;
                        if (!disp_next) begin
                            disp_color_q <= fl_oob_q ? '0 : mem_rdata;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
                if (pop) begin
                    mem_we_q        <= 1'b1;
                    mem_addr_q      <= head_addr;
                    mem_wdata_q     <= head_data;
                    wr_frame_done_q <= (head_addr == LAST_ADDR);
                end
            end
        end
    end

    assign disp_color    = disp_color_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign wr_frame_done = wr_frame_done_q;

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Scoreboard bench for oled_fb_arbiter: behavioural RAM, write/read expectation queues, directed phases.
module tb_oled_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  disp_x = '0;
    logic [5:0]  disp_y = '0;
    logic        disp_next = 1'b0;
    logic [15:0] disp_color;
    logic        cam_valid = 1'b0;
    logic        cam_ready;
    logic        cam_sof = 1'b0;
    logic [15:0] cam_data = '0;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        wr_frame_done;

    oled_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .disp_x(disp_x), .disp_y(disp_y), .disp_next(disp_next), .disp_color(disp_color),
        .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_sof(cam_sof), .cam_data(cam_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_frame_done(wr_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [15:0] data; } wr_t;
    typedef struct { int due; logic [15:0] val; } rd_t;
    typedef struct { int due; int addr; bit chk_a; } ad_t;

    wr_t wq[$];
    rd_t rq[$];
    ad_t aq[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    int exp_cnt = 0;
    logic [15:0] last_color = '0;
    bit stop_reads = 1'b0;

    logic [15:0] ram [0:4799];
    bit          written [0:4799];

    function automatic logic [15:0] pix(int a);
        return 16'(a * 37 + 'hF800);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (int'(mem_addr) < 4800) begin
            if (mem_we) begin
                ram[int'(mem_addr)]     <= mem_wdata;
                written[int'(mem_addr)] <= 1'b1;
            end
            mem_rdata <= written[int'(mem_addr)] ? ram[int'(mem_addr)] : pix(int'(mem_addr));
        end else begin
            mem_rdata <= '0;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (wr_frame_done) n_done++;
        if (mem_we) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", 32'(mem_we), 32'd0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
                check("frame_done", 32'(wr_frame_done), 32'(e.addr == 4799));
            end
        end
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ad_t a;
            a = aq.pop_front();
            check("rd_due_addr", 32'(a.due), 32'(cyc));
            check("rd_we", 32'(mem_we), 32'd0);
            if (a.chk_a) check("rd_addr", 32'(mem_addr), 32'(a.addr));
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            rd_t r;
            r = rq.pop_front();
            check("rd_due_color", 32'(r.due), 32'(cyc));
            check("disp_color", 32'(disp_color), 32'(r.val));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(int x, int y, logic [15:0] expv, bit chk_a, int expa);
        disp_x = 7'(x);
        disp_y = 6'(y);
        disp_next = 1'b1;
        aq.push_back('{cyc + 2, expa, chk_a});
        rq.push_back('{cyc + 4, expv});
        last_color = expv;
        tick();
        disp_next = 1'b0;
    endtask

    task automatic cam_beat(bit sof);
        int a;
        bit acc;
        a = sof ? 0 : exp_cnt;
        acc = 1'b0;
        cam_valid = 1'b1;
        cam_sof = sof;
        cam_data = pix(a);
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = cam_ready;
            if (acc) wq.push_back('{a, pix(a)});
            tick();
        end
        if (!acc) check("cam_accept_timeout", 32'(acc), 32'd1);
        exp_cnt = (a == 4799) ? 0 : a + 1;
        cam_valid = 1'b0;
        cam_sof = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && (wq.size() + rq.size() + aq.size()) > 0; t++) tick();
        check("idle_timeout", 32'(wq.size() + rq.size() + aq.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int errs;
        int a;
        for (int i = 0; i < 4800; i++) written[i] = 1'b0;

        // Reset state and the automatic read of (0,0) on release.
        repeat (3) tick();
        check("rst_disp_color", 32'(disp_color), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_frame_done", 32'(wr_frame_done), 32'd0);
        check("rst_cam_ready", 32'(cam_ready), 32'd0);
        reset = 1'b0;
        aq.push_back('{cyc + 1, 0, 1'b1});
        rq.push_back('{cyc + 2, 16'h0000});
        rq.push_back('{cyc + 3, 16'hF800});
        last_color = 16'hF800;
        tick();
        check("cam_ready_after_rst", 32'(cam_ready), 32'd1);
        wait_idle();

        // Single write latency into an empty FIFO.
        cam_valid = 1'b1;
        cam_data = pix(exp_cnt);
        wq.push_back('{exp_cnt, pix(exp_cnt)});
        exp_cnt++;
        tick();
        cam_valid = 1'b0;
        check("wr_lat_early", 32'(mem_we), 32'd0);
        tick();
        check("wr_lat", 32'(mem_we), 32'd1);
        wait_idle();

        // Corner pixel, out-of-range pixel, superseded read.
        do_read(79, 59, pix(4799), 1'b1, 4799);
        wait_idle();
        do_read(80, 0, 16'h0000, 1'b1, 4799);
        wait_idle();
        do_read(1, 0, last_color, 1'b1, 1);
        do_read(2, 0, pix(2), 1'b1, 2);
        wait_idle();

        // Back-to-back reads starve the FIFO until it fills.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            disp_x = 7'd5;
            disp_y = 6'd1;
            disp_next = 1'b1;
            cam_valid = 1'b1;
            cam_data = pix(exp_cnt);
            if (cam_ready) begin
                wq.push_back('{exp_cnt, pix(exp_cnt)});
                exp_cnt++;
                acc_cnt++;
            end
            if (i == 7) begin
                aq.push_back('{cyc + 2, 85, 1'b1});
                rq.push_back('{cyc + 3, last_color});
                rq.push_back('{cyc + 4, pix(85)});
                last_color = pix(85);
            end
            tick();
        end
        disp_next = 1'b0;
        cam_valid = 1'b0;
        check("fill_accepted", 32'(acc_cnt), 32'd4);
        check("fill_cam_ready", 32'(cam_ready), 32'd0);
        wait_idle();
        check("drain_cam_ready", 32'(cam_ready), 32'd1);

        // Full frame at full rate with periodic scan reads.
        n_done = 0;
        stop_reads = 1'b0;
        fork
            begin
                cam_beat(1'b1);
                for (int i = 1; i < 4800; i++) cam_beat(1'b0);
                stop_reads = 1'b1;
            end
            begin
                while (!stop_reads) begin
                    int x;
                    int y;
                    x = $urandom_range(79);
                    y = $urandom_range(59);
                    do_read(x, y, pix(y * 80 + x), 1'b1, y * 80 + x);
                    for (int t = 0; t < 31 && !stop_reads; t++) tick();
                end
            end
        join
        wait_idle();
        check("frame_done_count", 32'(n_done), 32'd1);

        // Frame aborted by cam_sof at counter 1234, then a complete frame.
        for (int i = 0; i < 1234; i++) cam_beat(1'b0);
        check("abort_counter", 32'(exp_cnt), 32'd1234);
        for (int i = 0; i < 4800; i++) cam_beat(i == 0);
        wait_idle();
        check("frame_done_after_abort", 32'(n_done), 32'd2);
        errs = 0;
        for (int i = 0; i < 4800; i++) if (!written[i] || ram[i] !== pix(i)) errs++;
        check("ram_contents", 32'(errs), 32'd0);

        // Reset with three queued writes and a read in flight.
        a = exp_cnt;
        for (int i = 0; i < 4; i++) begin
            disp_x = 7'd3;
            disp_y = 6'd0;
            disp_next = 1'b1;
            cam_valid = (i < 3);
            cam_data = 16'hDEAD;
            tick();
        end
        disp_next = 1'b0;
        cam_valid = 1'b0;
        reset = 1'b1;
        wq.delete();
        rq.delete();
        aq.delete();
        exp_cnt = 0;
        repeat (2) tick();
        check("rst2_disp_color", 32'(disp_color), 32'd0);
        check("rst2_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        aq.push_back('{cyc + 1, 0, 1'b1});
        rq.push_back('{cyc + 3, 16'hF800});
        repeat (12) tick();
        wait_idle();
        check("rst2_cam_ready", 32'(cam_ready), 32'd1);
        check("rst2_no_frame_done", 32'(n_done), 32'd2);
        check("rst2_ram_untouched", 32'(written[a] ? ram[a] : pix(a)), 32'(pix(a)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
